// File: rtl/shift_pkg.sv
// Shared encodings and step helper for the 8-bit sequential left shifter.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int MAX_STEP = 3;

    // Largest step the 2-bit shifter can take without overshooting rem.
    function automatic logic [1:0] step_of(input logic [2:0] rem);
        if (rem > 3'(MAX_STEP))
            return 2'(MAX_STEP);
        return rem[1:0];
    endfunction

endpackage

// File: rtl/shift_seq8_lsl8.sv
// LSL8: 8-bit logical shift left by 0..3, zero-filled.
module lsl8 (
    input  logic [7:0] d_in,
    input  logic [1:0] shamt,
    output logic [7:0] d_out
);

    assign d_out = d_in << shamt;

endmodule

// File: rtl/shift_seq8.sv
// Multi-cycle 8-bit left shifter: up to three bit positions per cycle.
module shift_seq8
    import shift_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] d_in,
    input  logic [2:0] amt,
    output logic [7:0] d_out,
    output logic       busy,
    output logic       done
);

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_rem;
    logic [2:0] w_next_rem;
    logic [7:0] r_dout;
    logic [7:0] w_next_dout;
    logic [7:0] w_shifted;
    logic [1:0] w_step;
    logic       r_done;

    assign w_step = step_of(r_rem);

    lsl8 u_lsl8 (
        .d_in  (r_dout),
        .shamt (w_step),
        .d_out (w_shifted)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_rem   = r_rem;
        w_next_dout  = r_dout;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_dout  = d_in;
                    w_next_rem   = amt;
                    w_next_state = (amt != 3'd0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                w_next_dout  = w_shifted;
                w_next_rem   = r_rem - {1'b0, w_step};
                w_next_state = (w_next_rem == 3'd0) ? DONE : SHIFT;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // done is registered so it rises on the same edge the FSM enters DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_rem   <= 3'd0;
            r_dout  <= 8'h00;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_rem   <= w_next_rem;
            r_dout  <= w_next_dout;
            r_done  <= (w_next_state == DONE);
        end
    end

    assign d_out = r_dout;
    assign done  = r_done;
    assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_shift_seq8.sv
// Directed-vector bench for shift_seq8.
module tb_shift_seq8;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] d_in;
    logic [2:0] amt;
    logic [7:0] d_out;
    logic       busy;
    logic       done;

    int n_vec;
    int n_err;
    int done_cnt;
    int snap;

    shift_seq8 dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .d_in  (d_in),
        .amt   (amt),
        .d_out (d_out),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (done === 1'b1)
            done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] e_d,
                              input logic e_busy, input logic e_done);
        chk({tag, ".d_out"}, {24'd0, d_out}, {24'd0, e_d});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
    endtask

    task automatic go(input logic [7:0] d, input logic [2:0] a);
        start = 1'b1;
        d_in  = d;
        amt   = a;
        tick();
        start = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        done_cnt = 0;
        reset    = 1'b1;
        start    = 1'b0;
        d_in     = 8'h00;
        amt      = 3'd0;
        tick();
        tick();
        expect_out("rst", 8'h00, 1'b0, 1'b0);

        // release and start on the very first edge: amt=0
        reset = 1'b0;
        go(8'hA5, 3'd0);
        expect_out("z.c1", 8'hA5, 1'b1, 1'b1);
        tick();
        expect_out("z.c2", 8'hA5, 1'b0, 1'b0);

        // single-bit walk, amt=7
        go(8'h01, 3'd7);
        expect_out("w.c1", 8'h01, 1'b1, 1'b0);
        tick();
        expect_out("w.c2", 8'h08, 1'b1, 1'b0);
        tick();
        expect_out("w.c3", 8'h40, 1'b1, 1'b0);
        tick();
        expect_out("w.c4", 8'h80, 1'b1, 1'b1);
        tick();
        expect_out("w.c5", 8'h80, 1'b0, 1'b0);

        // two-step, then back-to-back in the IDLE cycle after done
        go(8'hFF, 3'd4);
        expect_out("t.c1", 8'hFF, 1'b1, 1'b0);
        tick();
        expect_out("t.c2", 8'hF8, 1'b1, 1'b0);
        tick();
        expect_out("t.c3", 8'hF0, 1'b1, 1'b1);
        tick();
        expect_out("b.idle", 8'hF0, 1'b0, 1'b0);
        go(8'h03, 3'd2);
        expect_out("b.c1", 8'h03, 1'b1, 1'b0);
        tick();
        expect_out("b.c2", 8'h0C, 1'b1, 1'b1);
        tick();

        // amt=3 discards high bits; amt=6 takes two full steps
        go(8'hB6, 3'd3);
        tick();
        expect_out("a3", 8'hB0, 1'b1, 1'b1);
        tick();
        go(8'h03, 3'd6);
        tick();
        expect_out("a6.c2", 8'h18, 1'b1, 1'b0);
        tick();
        expect_out("a6.c3", 8'hC0, 1'b1, 1'b1);
        tick();

        // start held high while busy must be ignored
        snap = done_cnt;
        go(8'h01, 3'd5);
        start = 1'b1;
        d_in  = 8'hFF;
        amt   = 3'd1;
        expect_out("sb.c1", 8'h01, 1'b1, 1'b0);
        tick();
        expect_out("sb.c2", 8'h08, 1'b1, 1'b0);
        tick();
        expect_out("sb.c3", 8'h20, 1'b1, 1'b1);
        tick();
        start = 1'b0;
        expect_out("sb.c4", 8'h20, 1'b0, 1'b0);
        tick();
        tick();
        chk("sb.dones", done_cnt - snap, 1);

        // reset in the second SHIFT cycle of amt=7
        go(8'h01, 3'd7);
        tick();
        expect_out("r.c2", 8'h08, 1'b1, 1'b0);
        snap  = done_cnt;
        reset = 1'b1;
        #1;
        expect_out("r.async", 8'h00, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        go(8'h81, 3'd1);
        expect_out("r.acc", 8'h81, 1'b1, 1'b0);
        tick();
        expect_out("r.done", 8'h02, 1'b1, 1'b1);
        tick();
        tick();
        chk("r.dones", done_cnt - snap, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
